// File: rtl/ifetch_q.sv
`timescale 1ns/1ps
// ifetch_q -- instruction prefetch queue
//
// Purpose:
//   Fetches sequential instructions from an instruction memory one request at
//   a time and buffers them in a DEPTH-entry FIFO of {pc, instr} pairs for a
//   downstream consumer. A branch redirect flushes the queue and restarts
//   fetching at the branch target. A request that is still in flight when the
//   redirect arrives is allowed to complete, and its data is thrown away.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  registered fetch request and address to memory
//   imem_ack/imem_rdata memory completion and data (ignored while imem_req=0)
//   ir_valid/ir_data/ir_pc  queue head presented to the consumer
//   ir_ready            consumer accepts the head this cycle
//   br_taken/br_addr    one-cycle redirect/flush pulse and its target
//   count/empty/full    queue occupancy
//
// Handshakes:
//   Consumer side: a transfer happens on a rising edge where ir_valid=1 and
//   ir_ready=1. ir_valid does not depend on ir_ready, and ir_ready while
//   ir_valid=0 has no effect.
//   Memory side: once imem_req rises, imem_addr holds until the edge where
//   imem_ack=1, which may be the first cycle of the request. imem_ack while
//   imem_req=0 is ignored.

module ifetch_q #(
  parameter int            AW       = 16,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [AW-1:0]           imem_addr,
  input  logic                    imem_ack,
  input  logic [DW-1:0]           imem_rdata,
  output logic                    ir_valid,
  output logic [DW-1:0]           ir_data,
  output logic [AW-1:0]           ir_pc,
  input  logic                    ir_ready,
  input  logic                    br_taken,
  input  logic [AW-1:0]           br_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Fetch side state
  logic [AW-1:0] r_fetch_pc;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_drop;

  // Queue state
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_mem_pc   [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];

  // Next-state and event wires
  logic          w_ack;
  logic          w_hold;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_issue;
  logic          w_req_next;
  logic          w_drop_next;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_fetch_pc_next;

  assign w_empty = (r_count == '0);

  // An ack only counts while a request is actually outstanding.
  assign w_ack  = r_req & imem_ack;
  // The current request stays outstanding past this edge.
  assign w_hold = r_req & ~imem_ack;

  // Acked data enters the queue unless it belongs to a request that was
  // overtaken by a redirect (drop flag) or a redirect lands in this very cycle.
  assign w_push = w_ack & ~r_drop & ~br_taken;

  // A flush wins over any same-cycle pop; popping an empty queue does nothing.
  assign w_pop  = ~w_empty & ir_ready & ~br_taken;

  always_comb begin
    w_count_next = r_count;
    if (br_taken) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // fetch_pc tracks the address of the request being issued or held. It only
  // advances when an ack actually delivers data into the queue, so a dropped
  // ack leaves it pointing at the redirect target.
  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    if (br_taken) begin
      w_fetch_pc_next = br_addr;
    end else if (w_push) begin
      w_fetch_pc_next = r_fetch_pc + AW'(1);
    end
  end

  // A new request is only launched when there is room for its data after this
  // edge; with one request in flight at most, the queue can never overflow.
  assign w_issue    = ~w_hold & (w_count_next < DEPTH_C);
  assign w_req_next = w_hold | w_issue;

  // The drop flag marks an in-flight request whose data must be discarded.
  // It is set by a redirect that finds the request still unacked, survives
  // further redirects, and clears on the ack it was waiting for.
  always_comb begin
    w_drop_next = r_drop;
    if (w_hold && br_taken) begin
      w_drop_next = 1'b1;
    end else if (w_ack) begin
      w_drop_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_drop     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_req      <= w_req_next;
      r_drop     <= w_drop_next;
      r_count    <= w_count_next;
      if (w_issue) begin
        r_addr <= w_fetch_pc_next;
      end
      if (br_taken) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
      end
    end
  end

  // Queue storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_addr;
      r_mem_data[r_wptr] <= imem_rdata;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign ir_valid  = ~w_empty;
  assign ir_pc     = r_mem_pc[r_rptr];
  assign ir_data   = r_mem_data[r_rptr];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = (r_count == DEPTH_C);

endmodule

// File: doc/ifetch_q.md
IFETCH_Q -- requirements
Module: ifetch_q

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AW, 16, instruction address width.
- DW, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of 2, >= 2.
- RESET_PC, 0, first fetch address after reset.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous, active-high.
- imem_req, out, 1, fetch request to instruction memory; registered.
- imem_addr, out, AW, fetch address; registered.
- imem_ack, in, 1, memory completes the current request this cycle.
- imem_rdata, in, DW, instruction data; valid only when imem_ack=1.
- ir_valid, out, 1, queue head is presented to the consumer.
- ir_data, out, DW, queue head instruction.
- ir_pc, out, AW, address of the queue head instruction.
- ir_ready, in, 1, consumer accepts the head this cycle.
- br_taken, in, 1, one-cycle redirect/flush pulse.
- br_addr, in, AW, redirect target; sampled when br_taken=1.
- count, out, log2(DEPTH)+1, number of valid queue entries.
- empty, out, 1, count==0.
- full, out, 1, count==DEPTH.

Function
REQ-003 The block SHALL hold a fetch_pc register and a FIFO of DEPTH {pc, instr} entries; ir_valid=!empty, and ir_data/ir_pc SHALL be the head entry.
REQ-004 Memory handshake:
- At most one request outstanding.
- Once imem_req=1, imem_addr SHALL be held stable until the cycle imem_ack=1.
- imem_ack is legal in the first cycle imem_req is high.
- imem_ack with imem_req=0 SHALL be ignored.
REQ-005 Each cycle, next imem_req SHALL be 1 iff:
- a request is outstanding and not acked this cycle, or
- no request remains outstanding after this cycle and count_next < DEPTH.
This gives one fetch per cycle when memory acks every cycle.
REQ-006 On a new issue, imem_addr SHALL load fetch_pc_next.
REQ-007 fetch_pc SHALL increment by 1 per accepted ack, wrapping from 2^AW-1 to 0.
REQ-008 On an ack that is not dropped (REQ-011), {imem_addr, imem_rdata} SHALL be pushed; the entry is visible on ir_valid the following cycle (1-cycle latency).
REQ-009 A pop SHALL occur when ir_valid && ir_ready.
- Simultaneous push and pop SHALL leave count unchanged.
- Overflow SHALL be impossible by construction (REQ-005).
- Pop when empty SHALL be a no-op.
REQ-010 br_taken=1 SHALL, in the same edge:
- empty the FIFO (flush overrides any same-cycle pop or push);
- set fetch_pc to br_addr.
REQ-011 If br_taken=1 while a request is outstanding and not acked that cycle:
- a drop flag SHALL be set;
- imem_req/imem_addr SHALL remain held (REQ-004);
- the eventual ack data SHALL be discarded and the drop flag cleared;
- fetch_pc SHALL NOT increment on that ack;
- the next request SHALL issue to br_addr in the following cycle.
REQ-012 If br_taken and imem_ack coincide:
- the acked data SHALL be discarded;
- no drop flag is set;
- the next request (to br_addr) SHALL issue in the following cycle.
REQ-013 A br_taken arriving while the drop flag is set SHALL only update fetch_pc; the flag stays set.

Reset
REQ-014 While rst=1 at an edge, the block SHALL set: FIFO empty, count=0, empty=1, full=0, ir_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, drop flag=0.
REQ-015 rst SHALL abandon any outstanding request; acks during or after the reset cycle for the abandoned request SHALL be ignored because imem_req=0.
REQ-016 The first request (addr RESET_PC) SHALL assert in the first cycle after rst deasserts.

Verification (DEPTH=4, AW=16, memory returns rdata=0x1000+addr)
REQ-017 Streaming: RESET_PC=0, ack every requested cycle, ir_ready=1 -> ir_pc 0,1,2,3,... on consecutive cycles, ir_data 0x1000,0x1001,...; count never exceeds 1.
REQ-018 Backpressure: ir_ready=0 -> after acks for addrs 0..3, full=1, count=4, imem_req=0; then ir_ready=1 for one cycle -> head pc 0 popped, imem_req=1 with imem_addr=4 next cycle.
REQ-019 Flush with in-flight request: req addr 3 outstanding, br_taken with br_addr=0x0040, ack 2 cycles later -> empty=1 immediately, addr-3 data never appears, next request imem_addr=0x0040, first ir_pc=0x0040 with ir_data=0x1040.
REQ-020 Coincident flush and ack: br_taken with br_addr=0x0100 in the ack cycle of addr 2 -> addr-2 data discarded, next request addr 0x0100.
REQ-021 Wrap: RESET_PC=0xFFFE -> ir_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-022 Reset mid-operation: queue full and request outstanding, rst=1 for one cycle -> next cycle empty=1, count=0, imem_req=0; a stray ack is ignored; req to RESET_PC one cycle after rst drops.
